// File: rtl/dvp_pkg.sv
// dvp_pkg: shared types and helpers for the DVP transmit/capture path.
//   dvp_tx_state_t : transmitter frame FSM states
//   rgb565_t       : RGB565 pixel, also used by the capture side
//   line_len()     : byte clocks per line (2 bytes per pixel plus blanking)
//   cnt_width()    : register width for a counter running 0..n-1
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } dvp_tx_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic int line_len(int h_act, int h_blank);
    return 2 * h_act + h_blank;
  endfunction

  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// dvp_tx_timing: frame FSM and line/byte counters for the DVP transmitter.
//   cam_pclk     : byte clock, rising edge
//   rst_n        : synchronous active-low reset
//   enable_i     : start/continue frames; only looked at on frame boundaries
//   state_o      : current frame segment
//   h_cnt_o      : byte position within the line, 0..LINE_LEN-1
//   href_win_o   : high during the 2*H_ACT data bytes of an ACTIVE line
//   last_line_o  : high throughout the last ACTIVE line
module dvp_tx_timing
  import dvp_pkg::*;
#(
  parameter int H_ACT    = 640,
  parameter int H_BLANK  = 144,
  parameter int V_ACT    = 480,
  parameter int VS_WIDTH = 4,
  parameter int V_BP     = 8,
  parameter int V_FP     = 8
) (
  input  logic                                          cam_pclk,
  input  logic                                          rst_n,
  input  logic                                          enable_i,
  output dvp_tx_state_t                                 state_o,
  output logic [cnt_width(line_len(H_ACT, H_BLANK))-1:0] h_cnt_o,
  output logic                                          href_win_o,
  output logic                                          last_line_o
);

  localparam int LINE_LEN = line_len(H_ACT, H_BLANK);
  localparam int H_W      = cnt_width(LINE_LEN);
  localparam int V_MAX1   = (VS_WIDTH > V_BP) ? VS_WIDTH : V_BP;
  localparam int V_MAX2   = (V_ACT > V_FP) ? V_ACT : V_FP;
  localparam int V_W      = cnt_width((V_MAX1 > V_MAX2) ? V_MAX1 : V_MAX2);

  localparam logic [H_W-1:0] H_LAST   = H_W'(LINE_LEN - 1);
  localparam logic [H_W-1:0] HB_LAST  = H_W'(2 * H_ACT - 1);
  localparam logic [V_W-1:0] VS_LAST  = V_W'(VS_WIDTH - 1);
  localparam logic [V_W-1:0] VBP_LAST = V_W'((V_BP > 0) ? V_BP - 1 : 0);
  localparam logic [V_W-1:0] VA_LAST  = V_W'(V_ACT - 1);
  localparam logic [V_W-1:0] VFP_LAST = V_W'((V_FP > 0) ? V_FP - 1 : 0);

  if (H_ACT < 1 || V_ACT < 1 || VS_WIDTH < 1) begin : g_bad_params
    $error("dvp_tx_timing: H_ACT, V_ACT and VS_WIDTH must all be >= 1");
  end

  dvp_tx_state_t  state_q;
  logic [H_W-1:0] h_cnt_q;
  logic [V_W-1:0] v_cnt_q;

  logic           line_wrap;
  logic [V_W-1:0] seg_last;
  dvp_tx_state_t  seg_next;

  assign line_wrap = (h_cnt_q == H_LAST);

  // Length of the current segment and where it leads. Zero-length porches
  // are skipped; enable is only consulted when leaving the final segment.
  always_comb begin
    seg_last = VS_LAST;
    seg_next = IDLE;
    case (state_q)
      VSYNC:  begin seg_last = VS_LAST;  seg_next = (V_BP > 0) ? VBP : ACTIVE; end
      VBP:    begin seg_last = VBP_LAST; seg_next = ACTIVE; end
      ACTIVE: begin
        seg_last = VA_LAST;
        seg_next = (V_FP > 0) ? VFP : (enable_i ? VSYNC : IDLE);
      end
      VFP:    begin seg_last = VFP_LAST; seg_next = enable_i ? VSYNC : IDLE; end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // in this block sees the pre-edge values of the others.
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      if (enable_i) state_q <= VSYNC;
    end else if (line_wrap) begin
      h_cnt_q <= '0;
      if (v_cnt_q == seg_last) begin
        v_cnt_q <= '0;
        state_q <= seg_next;
      end else begin
        v_cnt_q <= v_cnt_q + 1'b1;
      end
    end else begin
      h_cnt_q <= h_cnt_q + 1'b1;
    end
  end

  assign state_o     = state_q;
  assign h_cnt_o     = h_cnt_q;
  assign href_win_o  = (state_q == ACTIVE) && (h_cnt_q <= HB_LAST);
  assign last_line_o = (state_q == ACTIVE) && (v_cnt_q == VA_LAST);

endmodule

// File: rtl/dvp_img_tx.sv
// dvp_img_tx: DVP transmitter / OV5640 emulator. Serialises RGB565 pixels
// (high byte first) onto an 8-bit DVP bus with programmable frame timing.
//   cam_pclk   : byte clock, rising edge
//   rst_n      : synchronous active-low reset
//   enable     : run frames; a started frame always completes
//   pix_data   : RGB565 pixel, pix_valid / pix_ready handshake
//   cam_vsync  : VS_POL during the vsync lines
//   cam_href   : high for the 2*H_ACT bytes of each active line
//   cam_data   : byte data, 0x00 outside href and for missed pixels
//   frame_done : one-cycle pulse with the last byte of the frame
//   underrun   : sticky, a pixel slot found pix_valid low
module dvp_img_tx
  import dvp_pkg::*;
#(
  parameter int H_ACT    = 640,
  parameter int H_BLANK  = 144,
  parameter int V_ACT    = 480,
  parameter int VS_WIDTH = 4,
  parameter int V_BP     = 8,
  parameter int V_FP     = 8,
  parameter bit VS_POL   = 1'b1
) (
  input  logic       cam_pclk,
  input  logic       rst_n,
  input  logic       enable,
  input  rgb565_t    pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       cam_vsync,
  output logic       cam_href,
  output logic [7:0] cam_data,
  output logic       frame_done,
  output logic       underrun
);

  localparam int H_W = cnt_width(line_len(H_ACT, H_BLANK));
  localparam logic [H_W-1:0] HB_LAST = H_W'(2 * H_ACT - 1);

  dvp_tx_state_t  state;
  logic [H_W-1:0] h_cnt;
  logic           href_win;
  logic           last_line;

  dvp_tx_timing #(
    .H_ACT    (H_ACT),
    .H_BLANK  (H_BLANK),
    .V_ACT    (V_ACT),
    .VS_WIDTH (VS_WIDTH),
    .V_BP     (V_BP),
    .V_FP     (V_FP)
  ) u_timing (
    .cam_pclk    (cam_pclk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .state_o     (state),
    .h_cnt_o     (h_cnt),
    .href_win_o  (href_win),
    .last_line_o (last_line)
  );

  logic       cam_vsync_q, cam_href_q, frame_done_q, underrun_q;
  logic [7:0] cam_data_q, cam_data_d;
  logic [7:0] lo_byte_q, lo_byte_d;
  logic       take;
  logic       frame_end;

  // Even byte positions of the href window are pixel slots.
  assign pix_ready = href_win && !h_cnt[0];
  assign take      = pix_ready && pix_valid;
  assign frame_end = last_line && (h_cnt == HB_LAST);

  // A missed slot sends 0x00 for both bytes and consumes nothing.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cam_data_d = 8'h00;
    lo_byte_d  = lo_byte_q;
    if (pix_ready) begin
      cam_data_d = take ? pix_data[15:8] : 8'h00;
      lo_byte_d  = take ? pix_data[7:0]  : 8'h00;
    end else if (href_win) begin
      cam_data_d = lo_byte_q;
    end
  end

  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      cam_vsync_q  <= ~VS_POL;
      cam_href_q   <= 1'b0;
      cam_data_q   <= 8'h00;
      lo_byte_q    <= 8'h00;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      cam_vsync_q  <= (state == VSYNC) ? VS_POL : ~VS_POL;
      cam_href_q   <= href_win;
      cam_data_q   <= cam_data_d;
      lo_byte_q    <= lo_byte_d;
      frame_done_q <= frame_end;
      if (pix_ready && !pix_valid) underrun_q <= 1'b1;
    end
  end

  assign cam_vsync  = cam_vsync_q;
  assign cam_href   = cam_href_q;
  assign cam_data   = cam_data_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_dvp_img_tx.sv
// tb_dvp_img_tx: randomized self-checking bench for dvp_img_tx. The reference
// model tracks a single position within the frame (or idle) and derives all
// expected outputs from line/column arithmetic.
module tb_dvp_img_tx;

  localparam int H_ACT       = 4;
  localparam int H_BLANK     = 6;
  localparam int V_ACT       = 3;
  localparam int VS_WIDTH    = 2;
  localparam int V_BP        = 1;
  localparam int V_FP        = 1;
  localparam int LINE_LEN    = 2 * H_ACT + H_BLANK;
  localparam int FRAME_LEN   = LINE_LEN * (VS_WIDTH + V_BP + V_ACT + V_FP);
  localparam int ACT_FIRST   = VS_WIDTH + V_BP;

  logic        cam_pclk  = 1'b0;
  logic        rst_n     = 1'b0;
  logic        enable    = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data  = 16'h0102;
  logic        pix_ready, cam_vsync, cam_href, frame_done, underrun;
  logic [7:0]  cam_data;

  always #5 cam_pclk = ~cam_pclk;

  dvp_img_tx #(
    .H_ACT    (H_ACT),
    .H_BLANK  (H_BLANK),
    .V_ACT    (V_ACT),
    .VS_WIDTH (VS_WIDTH),
    .V_BP     (V_BP),
    .V_FP     (V_FP),
    .VS_POL   (1'b1)
  ) dut (
    .cam_pclk   (cam_pclk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  // Reference model state.
  int         pos = -1;   // cycle within frame, -1 when idle
  logic       exp_vsync = 1'b0, exp_href = 1'b0, exp_fd = 1'b0, exp_ur = 1'b0;
  logic       exp_ready = 1'b0;
  logic [7:0] exp_data = 8'h00, exp_lo = 8'h00;
  logic [12:0] exp_vec = '0;
  wire  [12:0] dut_vec = {cam_vsync, cam_href, cam_data, pix_ready, frame_done, underrun};

  bit  seq_mode = 1'b1;
  int  seq_k    = 0;
  int  dut_hs   = 0;
  int  cyc      = 0;
  int  vectors  = 0;
  int  miscompares = 0;

  function automatic bit href_at(int p);
    int l, c;
    if (p < 0) return 1'b0;
    l = p / LINE_LEN;
    c = p % LINE_LEN;
    return (l >= ACT_FIRST) && (l < ACT_FIRST + V_ACT) && (c < 2 * H_ACT);
  endfunction

  function automatic bit slot_at(int p);
    return href_at(p) && ((p % LINE_LEN) % 2 == 0);
  endfunction

  function automatic logic [15:0] seq_pixel(int k);
    logic [7:0] hi, lo;
    hi = 8'(2 * k + 1);
    lo = 8'(2 * k + 2);
    return {hi, lo};
  endfunction

  // One clock: compute expectations from pre-edge inputs, clock, settle.
  task automatic step();
    bit slot, hs;
    slot = slot_at(pos);
    hs   = slot && pix_valid && rst_n;
    if (pix_valid && pix_ready) dut_hs++;
    if (!rst_n) begin
      exp_vsync = 1'b0; exp_href = 1'b0; exp_data = 8'h00;
      exp_lo = 8'h00; exp_fd = 1'b0; exp_ur = 1'b0;
      pos = -1;
    end else begin
      exp_vsync = (pos >= 0) && (pos / LINE_LEN < VS_WIDTH);
      exp_href  = href_at(pos);
      if (slot) begin
        exp_data = pix_valid ? pix_data[15:8] : 8'h00;
        exp_lo   = pix_valid ? pix_data[7:0]  : 8'h00;
        if (!pix_valid) exp_ur = 1'b1;
      end else begin
        exp_data = exp_href ? exp_lo : 8'h00;
      end
      exp_fd = exp_href && (pos % LINE_LEN == 2 * H_ACT - 1) &&
               (pos / LINE_LEN == ACT_FIRST + V_ACT - 1);
      if (pos < 0 || pos == FRAME_LEN - 1) pos = enable ? 0 : -1;
      else pos++;
    end
    @(posedge cam_pclk);
    #1;
    exp_ready = slot_at(pos);
    exp_vec   = {exp_vsync, exp_href, exp_data, exp_ready, exp_fd, exp_ur};
    cyc++;
    if (hs) begin
      seq_k++;
      pix_data = seq_mode ? seq_pixel(seq_k) : 16'($urandom);
    end
  endtask

  task automatic apply_reset(int n, bit seq);
    rst_n = 1'b0;
    seq_mode = seq;
    seq_k = 0;
    pix_data = seq ? seq_pixel(0) : 16'($urandom);
    repeat (n) step();
    rst_n = 1'b1;
    dut_hs = 0;
  endtask

  task automatic test_reset();
    enable = 1'b1; pix_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) begin
      step(); vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single_frame();
    int vs_cnt = 0, href_rise = 0, fd_cnt = 0;
    logic prev_href = 1'b0;
    logic [7:0] fd_byte = 8'h00;
    apply_reset(2, 1'b1);
    enable = 1'b1; pix_valid = 1'b1;
    repeat (FRAME_LEN + 1) begin
      step(); vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL single_frame cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (cam_vsync === 1'b1) vs_cnt++;
      if (cam_href === 1'b1 && !prev_href) href_rise++;
      prev_href = cam_href;
      if (frame_done === 1'b1) begin fd_cnt++; fd_byte = cam_data; end
    end
    vectors++;
    if (vs_cnt != LINE_LEN * VS_WIDTH) begin
      miscompares++; $display("FAIL vsync_width got=%0d exp=%0d", vs_cnt, LINE_LEN * VS_WIDTH);
    end
    vectors++;
    if (href_rise != V_ACT) begin
      miscompares++; $display("FAIL href_pulses got=%0d exp=%0d", href_rise, V_ACT);
    end
    vectors++;
    if (fd_cnt != 1) begin
      miscompares++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt);
    end
    vectors++;
    if (fd_byte !== 8'h18) begin
      miscompares++; $display("FAIL frame_done_byte got=%h exp=18", fd_byte);
    end
  endtask

  task automatic test_back_to_back();
    int rises[$];
    logic prev_vs = 1'b0;
    apply_reset(2, 1'b0);
    enable = 1'b1; pix_valid = 1'b1;
    repeat (3 * FRAME_LEN + 1) begin
      step(); vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (cam_vsync === 1'b1 && !prev_vs) rises.push_back(cyc);
      prev_vs = cam_vsync;
    end
    vectors++;
    if (rises.size() != 3) begin
      miscompares++; $display("FAIL vsync_rises got=%0d exp=3", rises.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (rises[i] - rises[i-1] != FRAME_LEN) begin
          miscompares++;
          $display("FAIL frame_period got=%0d exp=%0d", rises[i] - rises[i-1], FRAME_LEN);
        end
      end
    end
    vectors++;
    if (dut_hs != 3 * H_ACT * V_ACT) begin
      miscompares++; $display("FAIL pixels_consumed got=%0d exp=%0d", dut_hs, 3 * H_ACT * V_ACT);
    end
    vectors++;
    if (underrun !== 1'b0) begin
      miscompares++; $display("FAIL no_underrun got=%b exp=0", underrun);
    end
  endtask

  task automatic test_underrun();
    apply_reset(2, 1'b1);
    enable = 1'b1;
    repeat (FRAME_LEN + 1) begin
      pix_valid = !(pos == ACT_FIRST * LINE_LEN + 2);
      step(); vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL underrun cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
    pix_valid = 1'b1;
    vectors++;
    if (underrun !== 1'b1) begin
      miscompares++; $display("FAIL underrun_sticky got=%b exp=1", underrun);
    end
    vectors++;
    if (dut_hs != H_ACT * V_ACT - 1) begin
      miscompares++; $display("FAIL underrun_consumed got=%0d exp=%0d", dut_hs, H_ACT * V_ACT - 1);
    end
  endtask

  task automatic test_enable_drop();
    int vs_rise = 0, href_rise = 0, fd_cnt = 0;
    logic prev_vs = 1'b0, prev_href = 1'b0;
    apply_reset(2, 1'b0);
    enable = 1'b1;
    repeat (250) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      if (pos >= 0 && pos / LINE_LEN == ACT_FIRST + 1) enable = 1'b0;
      step(); vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL enable_drop cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (cam_vsync === 1'b1 && !prev_vs) vs_rise++;
      if (cam_href === 1'b1 && !prev_href) href_rise++;
      if (frame_done === 1'b1) fd_cnt++;
      prev_vs = cam_vsync;
      prev_href = cam_href;
    end
    vectors++;
    if (vs_rise != 1) begin
      miscompares++; $display("FAIL drop_vsync_count got=%0d exp=1", vs_rise);
    end
    vectors++;
    if (href_rise != V_ACT) begin
      miscompares++; $display("FAIL drop_href_pulses got=%0d exp=%0d", href_rise, V_ACT);
    end
    vectors++;
    if (fd_cnt != 1) begin
      miscompares++; $display("FAIL drop_frame_done got=%0d exp=1", fd_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int vs_cnt = 0;
    apply_reset(2, 1'b1);
    enable = 1'b1; pix_valid = 1'b1;
    for (int i = 0; i < 200 && pos != ACT_FIRST * LINE_LEN + 3; i++) begin
      step(); vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL mid_reset_pre cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if ({cam_href, cam_data} !== 9'h000) begin
      miscompares++; $display("FAIL mid_reset_outputs got=%h exp=000", {cam_href, cam_data});
    end
    vectors++;
    if (dut_vec !== exp_vec) begin
      miscompares++; $display("FAIL mid_reset cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
    end
    repeat (40) begin
      step(); vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL mid_reset_post cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (cam_vsync === 1'b1) vs_cnt++;
    end
    vectors++;
    if (vs_cnt != LINE_LEN * VS_WIDTH) begin
      miscompares++; $display("FAIL restart_vsync got=%0d exp=%0d", vs_cnt, LINE_LEN * VS_WIDTH);
    end
  endtask

  task automatic test_random();
    apply_reset(2, 1'b0);
    enable = 1'b1;
    repeat (700) begin
      pix_valid = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      step(); vectors++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_enable_drop();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
